traffic_light_ctrl: RTL and testbench

Traffic-light controller that drives the shared countdown timer as its initiator. It issues `start_timer`/`value` load requests, waits on `expired`, and uses the timer's `one_hz_enable`/`two_hz_enable` pulses to blink the pedestrian lamp. It sits beside the timer in the T2 top level; the top level wires the timer's outputs to this block's inputs and this block's `start_timer`/`value` to the timer. It sequences main-street and side-street lamps, with one optional sensor-driven green extension and a pedestrian walk phase.

---
 rtl/traffic_pkg.sv | 22 ++
 rtl/traffic_light_ctrl_if.sv | 27 ++
 rtl/lamp_decode.sv | 25 ++
 rtl/traffic_light_ctrl.sv | 118 +++++++++++
 tb/tb_traffic_light_ctrl.sv | 344 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/traffic_pkg.sv
// Shared types and constants for the traffic-light controller and its lamp decoder.
package traffic_pkg;

  localparam int TMR_W = 5;

  typedef enum logic [2:0] {
    ST_INIT       = 3'd0,
    ST_MG         = 3'd1,
    ST_MG_EXT     = 3'd2,
    ST_MY         = 3'd3,
    ST_SG         = 3'd4,
    ST_SY         = 3'd5,
    ST_WALK       = 3'd6,
    ST_WALK_BLINK = 3'd7
  } state_t;

  // Lamp codes are {red, yellow, green}, one-hot.
  localparam logic [2:0] LAMP_RED = 3'b100;
  localparam logic [2:0] LAMP_YEL = 3'b010;
  localparam logic [2:0] LAMP_GRN = 3'b001;

endpackage

// File: rtl/traffic_light_ctrl_if.sv
// Load/expiry handshake between the traffic-light controller (master) and the countdown timer (slave).
interface traffic_light_ctrl_if;
  import traffic_pkg::*;

  logic             start_timer;
  logic [TMR_W-1:0] value;
  logic             expired;
  logic             one_hz_enable;
  logic             two_hz_enable;

  modport master (
    output start_timer,
    output value,
    input  expired,
    input  one_hz_enable,
    input  two_hz_enable
  );

  modport slave (
    input  start_timer,
    input  value,
    output expired,
    output one_hz_enable,
    output two_hz_enable
  );

endinterface

// File: rtl/lamp_decode.sv
// Combinational map from controller state to main/side lamp codes; the parent registers the result.
module lamp_decode
  import traffic_pkg::*;
(
  input  state_t     state_i,
  output logic [2:0] main_lamp_o,
  output logic [2:0] side_lamp_o
);

  always_comb begin
    main_lamp_o = LAMP_RED;
    side_lamp_o = LAMP_RED;
    case (state_i)
      ST_MG, ST_MG_EXT: main_lamp_o = LAMP_GRN;
      ST_MY:            main_lamp_o = LAMP_YEL;
      ST_SG:            side_lamp_o = LAMP_GRN;
      ST_SY:            side_lamp_o = LAMP_YEL;
      default: begin
        main_lamp_o = LAMP_RED;
        side_lamp_o = LAMP_RED;
      end
    endcase
  end

endmodule

// File: rtl/traffic_light_ctrl.sv
// Traffic-light sequencer: drives the shared countdown timer, sequences main/side lamps,
// one optional sensor extension per main green, and a pedestrian walk/blink phase.
module traffic_light_ctrl
  import traffic_pkg::*;
#(
  parameter logic [TMR_W-1:0] T_BASE  = 5'd6,
  parameter logic [TMR_W-1:0] T_EXT   = 5'd3,
  parameter logic [TMR_W-1:0] T_YEL   = 5'd2,
  parameter logic [TMR_W-1:0] T_SIDE  = 5'd4,
  parameter logic [TMR_W-1:0] T_WALK  = 5'd5,
  parameter logic [TMR_W-1:0] T_BLINK = 5'd3
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 sensor,
  input  logic                 walk_req,
  traffic_light_ctrl_if.master tmr,
  output logic [2:0]           main_lamp,
  output logic [2:0]           side_lamp,
  output logic                 walk_lamp
);

  if (T_BASE == '0 || T_EXT == '0 || T_YEL == '0 ||
      T_SIDE == '0 || T_WALK == '0 || T_BLINK == '0) begin : g_param_check
    $error("traffic_light_ctrl: timer parameters must lie in 1..31");
  end

  state_t           state_q, state_d;
  logic             start_q, start_d;
  logic [TMR_W-1:0] value_q, value_d;
  logic [2:0]       main_q, main_d;
  logic [2:0]       side_q, side_d;
  logic             walk_lamp_q, walk_lamp_d;
  logic             walk_pend_q, walk_pend_d;
  logic             advance;

  function automatic logic [TMR_W-1:0] load_value(state_t s);
    case (s)
      ST_MG:         return T_BASE;
      ST_MG_EXT:     return T_EXT;
      ST_MY, ST_SY:  return T_YEL;
      ST_SG:         return T_SIDE;
      ST_WALK:       return T_WALK;
      ST_WALK_BLINK: return T_BLINK;
      default:       return '0;
    endcase
  endfunction

  // An expiry seen while our own load is in flight belongs to the previous interval.
  always_comb begin
    advance = tmr.expired && !start_q;
    state_d = state_q;
    case (state_q)
      ST_INIT:       state_d = ST_MG;
      ST_MG:         if (advance) state_d = sensor ? ST_MG_EXT : ST_MY;
      ST_MG_EXT:     if (advance) state_d = ST_MY;
      ST_MY:         if (advance) state_d = ST_SG;
      ST_SG:         if (advance) state_d = ST_SY;
      ST_SY:         if (advance) state_d = walk_pend_q ? ST_WALK : ST_MG;
      ST_WALK:       if (advance) state_d = ST_WALK_BLINK;
      ST_WALK_BLINK: if (advance) state_d = ST_MG;
      default:       state_d = ST_INIT;
    endcase
  end

  always_comb begin
    start_d = (state_d != state_q);
    value_d = start_d ? load_value(state_d) : value_q;

    walk_pend_d = walk_pend_q;
    if (state_d == ST_WALK && state_q != ST_WALK) begin
      walk_pend_d = 1'b0;
    end else if (walk_req) begin
      walk_pend_d = 1'b1;
    end

    walk_lamp_d = 1'b0;
    if (state_d == ST_WALK) begin
      walk_lamp_d = 1'b1;
    end else if (state_d == ST_WALK_BLINK) begin
      walk_lamp_d = (state_q != ST_WALK_BLINK) ? 1'b1
                  : walk_lamp_q ^ (tmr.one_hz_enable | tmr.two_hz_enable);
    end
  end

  lamp_decode u_lamp_decode (
    .state_i     (state_d),
    .main_lamp_o (main_d),
    .side_lamp_o (side_d)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ST_INIT;
      start_q     <= 1'b0;
      value_q     <= '0;
      main_q      <= LAMP_RED;
      side_q      <= LAMP_RED;
      walk_lamp_q <= 1'b0;
      walk_pend_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      start_q     <= start_d;
      value_q     <= value_d;
      main_q      <= main_d;
      side_q      <= side_d;
      walk_lamp_q <= walk_lamp_d;
      walk_pend_q <= walk_pend_d;
    end
  end

  assign tmr.start_timer = start_q;
  assign tmr.value       = value_q;
  assign main_lamp       = main_q;
  assign side_lamp       = side_q;
  assign walk_lamp       = walk_lamp_q;

endmodule

// File: tb/tb_traffic_light_ctrl.sv
// Directed bench for traffic_light_ctrl with a behavioural countdown timer on the interface.
module tb_traffic_light_ctrl;
  import traffic_pkg::*;

  logic       clock    = 1'b0;
  logic       reset    = 1'b1;
  logic       sensor   = 1'b0;
  logic       walk_req = 1'b0;
  logic       force_exp = 1'b0;
  logic [2:0] main_lamp;
  logic [2:0] side_lamp;
  logic       walk_lamp;

  int vectors     = 0;
  int miscompares = 0;

  traffic_light_ctrl_if tmr();

  traffic_light_ctrl dut (
    .clock     (clock),
    .reset     (reset),
    .sensor    (sensor),
    .walk_req  (walk_req),
    .tmr       (tmr),
    .main_lamp (main_lamp),
    .side_lamp (side_lamp),
    .walk_lamp (walk_lamp)
  );

  always #5 clock = ~clock;

  // Timer model: load on start, expired from N cycles after the start cycle until reloaded,
  // one_hz at elapsed N/2, two_hz at elapsed N.
  logic       run;
  int         el;
  logic [4:0] n;

  always @(posedge clock) begin
    if (reset) begin
      run <= 1'b0;
      el  <= 0;
      n   <= 5'd0;
    end else if (tmr.start_timer) begin
      run <= 1'b1;
      el  <= 1;
      n   <= tmr.value;
    end else if (run && el < 100) begin
      el <= el + 1;
    end
  end

  assign tmr.expired       = force_exp | (run && el >= int'(n));
  assign tmr.one_hz_enable = run && (el == int'(n) / 2);
  assign tmr.two_hz_enable = run && (el == int'(n));

  task automatic wait_start(output int cyc, output bit ok);
    ok  = 1'b0;
    cyc = 0;
    while (!ok && cyc < 200) begin
      @(negedge clock);
      cyc++;
      if (tmr.start_timer === 1'b1) ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clock);
    vectors++;
    if (tmr.start_timer !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_start: got %b want 0", tmr.start_timer);
    end
    vectors++;
    if (tmr.value !== 5'd0) begin
      miscompares++;
      $display("FAIL reset_value: got %0d want 0", tmr.value);
    end
    vectors++;
    if ({main_lamp, side_lamp, walk_lamp} !== {3'b100, 3'b100, 1'b0}) begin
      miscompares++;
      $display("FAIL reset_lamps: got %b_%b_%b want 100_100_0", main_lamp, side_lamp, walk_lamp);
    end
    vectors++;
    if (dut.walk_pend_q !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_walk_pend: got %b want 0", dut.walk_pend_q);
    end
    reset = 1'b0;
  endtask

  task automatic test_basic_cycle();
    logic [4:0] vals  [5] = '{5'd6, 5'd2, 5'd4, 5'd2, 5'd6};
    logic [2:0] mains [5] = '{3'b001, 3'b010, 3'b100, 3'b100, 3'b001};
    logic [2:0] sides [5] = '{3'b100, 3'b100, 3'b001, 3'b010, 3'b100};
    int cyc;
    bit ok;
    for (int i = 0; i < 5; i++) begin
      wait_start(cyc, ok);
      vectors++;
      if (!ok) begin
        miscompares++;
        $display("FAIL basic_timeout[%0d]: got no start want start", i);
        return;
      end
      if (i == 0) begin
        vectors++;
        if (cyc != 1) begin
          miscompares++;
          $display("FAIL basic_first_start_latency: got %0d want 1", cyc);
        end
      end
      vectors++;
      if (tmr.value !== vals[i]) begin
        miscompares++;
        $display("FAIL basic_value[%0d]: got %0d want %0d", i, tmr.value, vals[i]);
      end
      vectors++;
      if ({main_lamp, side_lamp, walk_lamp} !== {mains[i], sides[i], 1'b0}) begin
        miscompares++;
        $display("FAIL basic_lamps[%0d]: got %b_%b_%b want %b_%b_0", i,
                 main_lamp, side_lamp, walk_lamp, mains[i], sides[i]);
      end
    end
  endtask

  task automatic test_extension();
    logic [4:0] vals  [2] = '{5'd3, 5'd2};
    logic [2:0] mains [2] = '{3'b001, 3'b010};
    int cyc;
    bit ok;
    sensor = 1'b1;
    for (int i = 0; i < 2; i++) begin
      wait_start(cyc, ok);
      vectors++;
      if (!ok || tmr.value !== vals[i]) begin
        miscompares++;
        $display("FAIL ext_value[%0d]: got %0d (ok=%b) want %0d", i, tmr.value, ok, vals[i]);
      end
      vectors++;
      if ({main_lamp, side_lamp} !== {mains[i], 3'b100}) begin
        miscompares++;
        $display("FAIL ext_lamps[%0d]: got %b_%b want %b_100", i, main_lamp, side_lamp, mains[i]);
      end
    end
    sensor = 1'b0;
  endtask

  task automatic test_walk_request();
    logic blink_exp [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
    int cyc;
    bit ok;
    wait_start(cyc, ok);
    vectors++;
    if (!ok || tmr.value !== 5'd4) begin
      miscompares++;
      $display("FAIL walk_sg_value: got %0d (ok=%b) want 4", tmr.value, ok);
    end
    walk_req = 1'b1;
    @(negedge clock);
    walk_req = 1'b0;
    wait_start(cyc, ok);
    vectors++;
    if (!ok || tmr.value !== 5'd2) begin
      miscompares++;
      $display("FAIL walk_sy_value: got %0d (ok=%b) want 2", tmr.value, ok);
    end
    wait_start(cyc, ok);
    vectors++;
    if (!ok || {tmr.value, main_lamp, side_lamp, walk_lamp} !== {5'd5, 3'b100, 3'b100, 1'b1}) begin
      miscompares++;
      $display("FAIL walk_entry: got v=%0d %b_%b_%b (ok=%b) want v=5 100_100_1",
               tmr.value, main_lamp, side_lamp, walk_lamp, ok);
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      vectors++;
      if ({tmr.start_timer, walk_lamp} !== 2'b01) begin
        miscompares++;
        $display("FAIL walk_solid[%0d]: got start=%b lamp=%b want start=0 lamp=1",
                 i, tmr.start_timer, walk_lamp);
      end
    end
    wait_start(cyc, ok);
    vectors++;
    if (!ok || cyc != 1 || tmr.value !== 5'd3 || walk_lamp !== blink_exp[0]) begin
      miscompares++;
      $display("FAIL blink_entry: got v=%0d lamp=%b cyc=%0d want v=3 lamp=1 cyc=1",
               tmr.value, walk_lamp, cyc);
    end
    for (int i = 1; i < 4; i++) begin
      @(negedge clock);
      vectors++;
      if (walk_lamp !== blink_exp[i]) begin
        miscompares++;
        $display("FAIL blink_lamp[%0d]: got %b want %b", i, walk_lamp, blink_exp[i]);
      end
    end
    wait_start(cyc, ok);
    vectors++;
    if (!ok || cyc != 1 || {tmr.value, main_lamp, walk_lamp} !== {5'd6, 3'b001, 1'b0}) begin
      miscompares++;
      $display("FAIL walk_exit_mg: got v=%0d main=%b lamp=%b cyc=%0d want v=6 main=001 lamp=0 cyc=1",
               tmr.value, main_lamp, walk_lamp, cyc);
    end
    vectors++;
    if (dut.walk_pend_q !== 1'b0) begin
      miscompares++;
      $display("FAIL walk_pend_after: got %b want 0", dut.walk_pend_q);
    end
  endtask

  task automatic test_expired_held();
    logic [4:0] vals [10] = '{5'd2, 5'd4, 5'd2, 5'd6, 5'd2, 5'd4, 5'd2, 5'd6, 5'd2, 5'd4};
    logic want;
    force_exp = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clock);
      want = ((i % 2) == 0);
      vectors++;
      if (tmr.start_timer !== want) begin
        miscompares++;
        $display("FAIL held_start[%0d]: got %b want %b", i, tmr.start_timer, want);
      end
      if (want) begin
        vectors++;
        if (tmr.value !== vals[i/2-1]) begin
          miscompares++;
          $display("FAIL held_value[%0d]: got %0d want %0d", i, tmr.value, vals[i/2-1]);
        end
      end
    end
    force_exp = 1'b0;
  endtask

  task automatic test_reset_mid_phase();
    logic [4:0] vals [4] = '{5'd2, 5'd4, 5'd2, 5'd6};
    int cyc;
    bit ok;
    walk_req = 1'b1;
    @(negedge clock);
    walk_req = 1'b0;
    @(negedge clock);
    vectors++;
    if (side_lamp !== 3'b001) begin
      miscompares++;
      $display("FAIL midreset_in_sg: got side=%b want 001", side_lamp);
    end
    reset = 1'b1;
    @(negedge clock);
    vectors++;
    if ({tmr.start_timer, main_lamp, side_lamp, walk_lamp} !== {1'b0, 3'b100, 3'b100, 1'b0}) begin
      miscompares++;
      $display("FAIL midreset_outputs: got start=%b %b_%b_%b want start=0 100_100_0",
               tmr.start_timer, main_lamp, side_lamp, walk_lamp);
    end
    vectors++;
    if (dut.walk_pend_q !== 1'b0) begin
      miscompares++;
      $display("FAIL midreset_walk_pend: got %b want 0", dut.walk_pend_q);
    end
    reset = 1'b0;
    wait_start(cyc, ok);
    vectors++;
    if (!ok || cyc != 1 || {tmr.value, main_lamp} !== {5'd6, 3'b001}) begin
      miscompares++;
      $display("FAIL midreset_restart: got v=%0d main=%b cyc=%0d want v=6 main=001 cyc=1",
               tmr.value, main_lamp, cyc);
    end
    for (int i = 0; i < 4; i++) begin
      wait_start(cyc, ok);
      vectors++;
      if (!ok || tmr.value !== vals[i]) begin
        miscompares++;
        $display("FAIL midreset_seq[%0d]: got %0d (ok=%b) want %0d", i, tmr.value, ok, vals[i]);
      end
    end
  endtask

  task automatic test_walk_req_on_entry();
    logic [4:0] pre  [3] = '{5'd2, 5'd4, 5'd2};
    logic [4:0] post [6] = '{5'd3, 5'd6, 5'd2, 5'd4, 5'd2, 5'd6};
    int cyc;
    bit ok;
    bit seen;
    for (int i = 0; i < 3; i++) begin
      wait_start(cyc, ok);
      vectors++;
      if (!ok || tmr.value !== pre[i]) begin
        miscompares++;
        $display("FAIL entry_pre[%0d]: got %0d (ok=%b) want %0d", i, tmr.value, ok, pre[i]);
      end
      if (i == 1) begin
        walk_req = 1'b1;
        @(negedge clock);
        walk_req = 1'b0;
      end
    end
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clock);
      if (tmr.expired === 1'b1 && tmr.start_timer === 1'b0) seen = 1'b1;
    end
    vectors++;
    if (!seen) begin
      miscompares++;
      $display("FAIL entry_sy_expiry: got no expiry want expiry");
    end
    walk_req = 1'b1;
    @(negedge clock);
    walk_req = 1'b0;
    vectors++;
    if ({tmr.start_timer, tmr.value} !== {1'b1, 5'd5}) begin
      miscompares++;
      $display("FAIL entry_walk: got start=%b v=%0d want start=1 v=5", tmr.start_timer, tmr.value);
    end
    vectors++;
    if (dut.walk_pend_q !== 1'b0) begin
      miscompares++;
      $display("FAIL entry_walk_pend: got %b want 0", dut.walk_pend_q);
    end
    for (int i = 0; i < 6; i++) begin
      wait_start(cyc, ok);
      vectors++;
      if (!ok || tmr.value !== post[i]) begin
        miscompares++;
        $display("FAIL entry_post[%0d]: got %0d (ok=%b) want %0d", i, tmr.value, ok, post[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic_cycle();
    test_extension();
    test_walk_request();
    test_expired_held();
    test_reset_mid_phase();
    test_walk_req_on_entry();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
